// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the data-memory slave state type.
// Imported by the slave and by the processor-side master logic.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_state_t;

  // Byte-lane mask of a transfer: byte -> one lane, half -> pair picked by addr[1], else all four.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] low);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << low;
      HSIZE_HALF: mask = low[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data memory: one write port with per-byte enables, asynchronous read.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write on the clock edge.
  // NOTE: the array has no reset branch; clearing a RAM on reset is neither wanted here nor mappable to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory slave: address decode, programmable wait states,
// two-cycle ERROR response, word (optionally byte/half) access.
// Optional feature macro: AHB_DMEM_BYTE_LANE_EN enables byte and halfword transfers.
module ahb_dmem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned       IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_CYCLES);

  ahb_slv_state_t   state, state_nx;
  logic [3:0]       wait_cnt, wait_cnt_nx;
  logic             pend, pend_nx;   // this cycle completes a legal transfer
  logic             dp_write;
  logic [IDX_W-1:0] dp_idx;
  logic [3:0]       dp_be;
  logic             accept, legal, size_ok;
  logic [31:0]      mem_rdata;

  assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  // Size/alignment legality of the request in the address phase.
  always_comb begin
`ifdef AHB_DMEM_BYTE_LANE_EN
    case (HSIZE)
      HSIZE_BYTE: size_ok = 1'b1;
      HSIZE_HALF: size_ok = !HADDR[0];
      HSIZE_WORD: size_ok = (HADDR[1:0] == 2'b00);
      default:    size_ok = 1'b0;
    endcase
`else
    size_ok = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00);
`endif
  end

  assign legal = ({1'b0, HADDR} < ADDR_LIMIT) && size_ok;

  // Next state, wait counter and bus response outputs.
  // NOTE: every output is defaulted before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    pend_nx     = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (state == ST_ERR2) HRESP = HRESP_ERROR;
        state_nx = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_nx = ST_ERR1;
          end else if (WAIT_CYCLES == 0) begin
            pend_nx = 1'b1;
          end else begin
            state_nx    = ST_WAIT;
            wait_cnt_nx = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt <= 4'd1) begin
          state_nx    = ST_IDLE;
          wait_cnt_nx = 4'd0;
          pend_nx     = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nx  = ST_ERR2;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      pend     <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      pend     <= pend_nx;
    end
  end

  // Capture the accepted address phase; datapath only, qualified later by pend.
  always_ff @(posedge clk) begin
    if (accept && HREADYOUT) begin
      dp_write <= HWRITE;
      dp_idx   <= HADDR[IDX_W+1:2];
      dp_be    <= lane_mask(HSIZE, HADDR[1:0]);
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (pend && dp_write && !rst),
    .be    (dp_be),
    .addr  (dp_idx),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA = (pend && !dp_write) ? mem_rdata : 32'h0;

endmodule
